// File: rtl/pixel_pipe_pkg.sv
// Shared types and mode decode helpers for the pixel mode router.
package pixel_pipe_pkg;

    localparam int MAX_PIXEL_BITS  = 24;
    localparam int PIXEL_WIDTH_OUT = 24;

    typedef enum logic [2:0] {
        MODE_GRAY_SOBEL     = 3'b000,
        MODE_SOBEL          = 3'b001,
        MODE_GRAY           = 3'b010,
        MODE_BYPASS         = 3'b011,
        MODE_GRAY_SOBEL_THR = 3'b100,
        MODE_GRAY_THR       = 3'b101
    } pp_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_START = 2'd2,
        ST_RUN   = 2'd3
    } pp_state_e;

    // The two unused encodings collapse onto bypass so nothing downstream sees them.
    function automatic pp_mode_e pp_normalize(input logic [2:0] m);
        pp_mode_e r;
        case (m)
            3'b110, 3'b111: r = MODE_BYPASS;
            default:        r = pp_mode_e'(m);
        endcase
        return r;
    endfunction

    function automatic logic mode_uses_gray(input pp_mode_e m);
        return (m == MODE_GRAY_SOBEL) || (m == MODE_GRAY) ||
               (m == MODE_GRAY_SOBEL_THR) || (m == MODE_GRAY_THR);
    endfunction

    function automatic logic mode_uses_sobel(input pp_mode_e m);
        return (m == MODE_GRAY_SOBEL) || (m == MODE_SOBEL) || (m == MODE_GRAY_SOBEL_THR);
    endfunction

endpackage

// File: rtl/gray_scale_core.sv
// RGB to gray: (R + 2G + B) / 4, one register stage, result qualified by px_rdy_o.
module gray_scale_core #(
    parameter int CH_W = 8
) (
    input  logic              clk_i,
    input  logic              nreset_i,
    input  logic              px_rdy_i,
    input  logic [3*CH_W-1:0] px_i,
    output logic [CH_W-1:0]   px_o,
    output logic              px_rdy_o
);
    logic [CH_W+1:0] sum;

    assign sum = {2'b00, px_i[3*CH_W-1:2*CH_W]} +
                 {1'b0, px_i[2*CH_W-1:CH_W], 1'b0} +
                 {2'b00, px_i[CH_W-1:0]};

    always_ff @(posedge clk_i) begin
        if (!nreset_i) begin
            px_o     <= '0;
            px_rdy_o <= 1'b0;
        end else begin
            px_rdy_o <= px_rdy_i;
            if (px_rdy_i) begin
                px_o <= sum[CH_W+1:2];
            end
        end
    end

endmodule

// File: rtl/pixel_fifo.sv
// Output FIFO: registered storage, head valid whenever count is non-zero.
import pixel_pipe_pkg::*;

module pixel_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = PIXEL_WIDTH_OUT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [W-1:0]               wr_data,
    input  logic                       rd_en,
    output logic [W-1:0]               rd_data,
    output logic                       rd_valid,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       drop
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          rd_fire;
    logic          wr_fire;

    assign rd_valid = (count != '0);
    assign full     = (count == CW'(DEPTH));
    assign rd_fire  = rd_en & rd_valid;
    // A read in the same cycle frees the slot, so a write into a full FIFO still lands.
    assign wr_fire  = wr_en & (~full | rd_fire);
    assign drop     = wr_en & full & ~rd_fire;
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(wr_fire) - CW'(rd_fire);
        end
    end

endmodule

// File: rtl/sobel_control.sv
// Horizontal [-1 0 +1] gradient magnitude on a pixel stream; start_sobel_i clears history.
module sobel_control #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         nreset_i,
    input  logic         start_sobel_i,
    input  logic         px_rdy_i,
    input  logic [W-1:0] px_i,
    output logic [W-1:0] px_o,
    output logic         px_rdy_o
);
    logic [W-1:0] prev1;
    logic [W-1:0] prev2;
    logic [W-1:0] mag;

    assign mag = (px_i >= prev2) ? (px_i - prev2) : (prev2 - px_i);

    always_ff @(posedge clk_i) begin
        if (!nreset_i || start_sobel_i) begin
            prev1    <= '0;
            prev2    <= '0;
            px_o     <= '0;
            px_rdy_o <= 1'b0;
        end else begin
            px_rdy_o <= px_rdy_i;
            if (px_rdy_i) begin
                px_o  <= mag;
                prev2 <= prev1;
                prev1 <= px_i;
            end
        end
    end

endmodule

// File: rtl/pixel_mode_router.sv
// Mode-switching pixel pipeline: gray / Sobel / threshold / bypass routed into an output FIFO.
import pixel_pipe_pkg::*;

module pixel_mode_router #(
    parameter int PIXEL_W      = MAX_PIXEL_BITS,
    parameter int GRAY_W       = 8,
    parameter int FIFO_DEPTH   = 8,
    parameter int RESERVE      = 4,
    parameter int DRAIN_CYCLES = 16
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [2:0]         mode_i,
    input  logic [GRAY_W-1:0]  thresh_i,
    input  logic               sof_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [PIXEL_W-1:0] in_pixel_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [PIXEL_W-1:0] out_pixel_o,
    output logic [2:0]         active_mode_o,
    output logic               overflow_o
);
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam int DCW = $clog2(DRAIN_CYCLES + 1);

    pp_state_e         state, state_next;
    pp_mode_e          mode_q, active_mode;
    logic [GRAY_W-1:0] thresh_q;
    logic [DCW-1:0]    drain_cnt;
    logic              latch, apply, start_sobel, ready, accept, changed, room;
    logic [CW-1:0]     fifo_count;

    // Handshake: a pixel moves on both ports only in a cycle where valid and ready are
    // both high; ready is pulled low for an SOF that must first trigger a mode switch.
    assign changed = (pp_normalize(mode_i) != mode_q) || (thresh_i != thresh_q);
    assign room    = (fifo_count <= CW'(FIFO_DEPTH - RESERVE));

    always_comb begin
        state_next  = state;
        ready       = 1'b0;
        latch       = 1'b0;
        apply       = 1'b0;
        start_sobel = 1'b0;
        case (state)
            ST_IDLE: begin
                ready = ~sof_i;
                if (in_valid_i && sof_i) begin
                    latch      = 1'b1;
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt == DCW'(DRAIN_CYCLES - 1)) begin
                    state_next = ST_START;
                end
            end
            ST_START: begin
                start_sobel = mode_uses_sobel(mode_q);
                apply       = 1'b1;
                state_next  = ST_RUN;
            end
            ST_RUN: begin
                if (sof_i && changed) begin
                    if (in_valid_i) begin
                        latch      = 1'b1;
                        state_next = ST_DRAIN;
                    end
                end else begin
                    ready = room;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state       <= ST_IDLE;
            mode_q      <= MODE_BYPASS;
            thresh_q    <= '0;
            active_mode <= MODE_BYPASS;
            drain_cnt   <= '0;
        end else begin
            state     <= state_next;
            drain_cnt <= (state == ST_DRAIN) ? drain_cnt + 1'b1 : '0;
            if (latch) begin
                mode_q   <= pp_normalize(mode_i);
                thresh_q <= thresh_i;
            end
            if (apply) begin
                active_mode <= mode_q;
            end
        end
    end

    assign in_ready_o    = ready;
    assign active_mode_o = active_mode;
    assign accept        = in_valid_i & ready & (state == ST_RUN);

    logic              core_nreset, gray_go, gray_rdy, sobel_go, sobel_rdy, sobel_from_gray;
    logic [GRAY_W-1:0] gray_px, sobel_in, sobel_px;

    assign core_nreset     = ~reset_i;
    assign gray_go         = accept & mode_uses_gray(active_mode);
    assign sobel_from_gray = (active_mode == MODE_GRAY_SOBEL) || (active_mode == MODE_GRAY_SOBEL_THR);
    assign sobel_in        = sobel_from_gray ? gray_px : in_pixel_i[GRAY_W-1:0];
    assign sobel_go        = sobel_from_gray ? gray_rdy : (accept & (active_mode == MODE_SOBEL));

    gray_scale_core #(.CH_W(GRAY_W)) u_gray (
        .clk_i    (clk_i),
        .nreset_i (core_nreset),
        .px_rdy_i (gray_go),
        .px_i     (in_pixel_i[3*GRAY_W-1:0]),
        .px_o     (gray_px),
        .px_rdy_o (gray_rdy)
    );

    sobel_control #(.W(GRAY_W)) u_sobel (
        .clk_i         (clk_i),
        .nreset_i      (core_nreset),
        .start_sobel_i (start_sobel),
        .px_rdy_i      (sobel_go),
        .px_i          (sobel_in),
        .px_o          (sobel_px),
        .px_rdy_o      (sobel_rdy)
    );

    logic               th_valid, byp_valid, wr_en, drop;
    logic [GRAY_W-1:0]  th_val;
    logic [PIXEL_W-1:0] byp_px, wr_data;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            th_valid   <= 1'b0;
            th_val     <= '0;
            byp_valid  <= 1'b0;
            byp_px     <= '0;
            overflow_o <= 1'b0;
        end else begin
            th_valid  <= (active_mode == MODE_GRAY_SOBEL_THR) ? sobel_rdy :
                         (active_mode == MODE_GRAY_THR) ? gray_rdy : 1'b0;
            th_val    <= ((active_mode == MODE_GRAY_SOBEL_THR ? sobel_px : gray_px) >= thresh_q)
                         ? '1 : '0;
            byp_valid <= accept & (active_mode == MODE_BYPASS);
            byp_px    <= in_pixel_i;
            if (drop) begin
                overflow_o <= 1'b1;
            end
        end
    end

    // Results in flight always belong to active_mode: the drain period empties the
    // pipeline before a newly latched mode is applied.
    always_comb begin
        wr_en   = 1'b0;
        wr_data = '0;
        case (active_mode)
            MODE_BYPASS: begin
                wr_en   = byp_valid;
                wr_data = byp_px;
            end
            MODE_GRAY: begin
                wr_en   = gray_rdy;
                wr_data = {{(PIXEL_W-GRAY_W){1'b0}}, gray_px};
            end
            MODE_GRAY_SOBEL, MODE_SOBEL: begin
                wr_en   = sobel_rdy;
                wr_data = {{(PIXEL_W-GRAY_W){1'b0}}, sobel_px};
            end
            MODE_GRAY_SOBEL_THR, MODE_GRAY_THR: begin
                wr_en   = th_valid;
                wr_data = {{(PIXEL_W-GRAY_W){1'b0}}, th_val};
            end
            default: ;
        endcase
    end

    pixel_fifo #(.DEPTH(FIFO_DEPTH), .W(PIXEL_W)) u_fifo (
        .clk      (clk_i),
        .reset    (reset_i),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (out_ready_i),
        .rd_data  (out_pixel_o),
        .rd_valid (out_valid_o),
        .count    (fifo_count),
        .drop     (drop)
    );

endmodule

// File: doc/pixel_mode_router.md
# pixel_mode_router

Parametrised, flow-controlled successor to the grayscale/Sobel top level. It wraps `gray_scale_core` and `sobel_control`, adds a threshold (binarisation) mode, and accepts mode changes only at frame boundaries after a drain period. An output FIFO gives a valid/ready interface toward the SPI/IO side. It sits between the input pixel deserialiser and the output serialiser.

## Interface
- `PIXEL_W`, default 24: input pixel width (RGB888); the output is the same width.
- `GRAY_W`, default 8: processed pixel width.
- `FIFO_DEPTH`, default 8: output FIFO entries; power of 2, ≥4.
- `RESERVE`, default 4: FIFO slots held back for pixels already in the cores; must be less than FIFO_DEPTH.
- `DRAIN_CYCLES`, default 16: idle cycles inserted before a new mode takes effect.
- `clk_i` in 1: single clock.
- `reset_i` in 1: reset; synchronous, active-high.
- `mode_i` in 3: requested mode, sampled on SOF.
- `thresh_i` in GRAY_W: threshold, sampled together with mode_i.
- `sof_i` in 1: start-of-frame; qualifies the current input pixel.
- `in_valid_i` in 1: input pixel valid.
- `in_ready_o` out 1: block accepts the pixel this cycle.
- `in_pixel_i` in PIXEL_W: input pixel.
- `out_valid_o` out 1: FIFO head valid.
- `out_ready_i` in 1: consumer takes the head this cycle.
- `out_pixel_o` out PIXEL_W: output pixel; zero-extended in every non-bypass mode.
- `active_mode_o` out 3: mode currently applied.
- `overflow_o` out 1: sticky flag; a core result was dropped because the FIFO was full.

## Operation
- Modes:
  - 000 gray→sobel.
  - 001 sobel only (input bits [7:0]).
  - 010 gray only.
  - 011 bypass.
  - 100 gray→sobel→threshold.
  - 101 gray→threshold.
  - 110 and 111 are treated as 011.
- Threshold rule: result = (value ≥ thresh_q) ? all-ones : 0, in GRAY_W bits. The comparison is unsigned, so thresh 0 always yields all-ones.
- Accept rule: a pixel is accepted when `in_valid_i & in_ready_o`. The accepted pulse drives `px_rdy_i` of the cores the mode uses; unused cores get 0. The Sobel input mux is unchanged: gray output in modes 000/100, raw [7:0] in mode 001.
- Core results, qualified by their `px_rdy_o`, and bypass pixels are written to the FIFO.
  - FIFO full at write → result dropped, `overflow_o` set until reset.
- FSM states: IDLE, DRAIN, START, RUN.
  - IDLE, entered at reset: in_ready_o=1. Non-SOF pixels are accepted and discarded. An SOF pixel is not accepted; it latches mode_q/thresh_q and moves to DRAIN.
  - DRAIN: in_ready_o=0. Counts DRAIN_CYCLES cycles, then moves to START.
  - START: in_ready_o=0. Issues a one-cycle `start_sobel_i` pulse if mode_q uses Sobel, applies active_mode_o=mode_q, then moves to RUN.
  - RUN: in_ready_o = (fifo_count ≤ FIFO_DEPTH−RESERVE).
    - SOF with mode_i and thresh_i equal to active → accepted normally.
    - SOF with a different mode_i or thresh_i → not accepted; latch the new values and go to DRAIN.
    - mode_i changes without SOF → ignored.
- The held SOF pixel is accepted in the first RUN cycle where in_ready_o=1, provided the source keeps it presented (AXI-style rule: valid is not withdrawn).
- Reset mid-operation: FSM to IDLE, FIFO emptied, cores reset via `nreset_i = ~reset_i`.

## Timing
- Reset values:
  - in_ready_o=1 (IDLE).
  - out_valid_o=0.
  - out_pixel_o=0.
  - active_mode_o=011.
  - overflow_o=0.
  - internal mode_q=011, thresh_q=0.
- Bypass latency: pixel accepted in cycle N → FIFO write at the edge ending N+1 → out_valid_o high in cycle N+2 when the FIFO was empty.
- Threshold adds one register stage after the core output.
- FIFO behaviour:
  - Head is registered and valid when count>0.
  - Simultaneous write and read with count=FIFO_DEPTH is a legal pass-through with no drop, because the read frees the slot first.
  - Read at count=0 is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- Mode switch: the SOF pixel presented in cycle N is accepted at the earliest in cycle N+DRAIN_CYCLES+2.
- out_pixel_o holds its value while out_valid_o is high and out_ready_i is low.

## Structure
- Package `pixel_pipe_pkg` holds:
  - mode enum `pp_mode_e`;
  - FSM enum `pp_state_e`;
  - the MAX_PIXEL_BITS and PIXEL_WIDTH_OUT constants.
- Sub-module `pixel_fifo`: parametrised depth and width, synchronous active-high reset, count output.
- The FSM, threshold stage and routing mux live in the top.

## Test plan
- Reset, then SOF with mode 011, DRAIN_CYCLES=16, pixel 0xA1B2C3 → accepted 18 cycles later; 0xA1B2C3 on out_pixel_o 2 cycles after acceptance; active_mode_o=011.
- Mode 101, thresh=0x80, gray inputs 0x7F7F7F and 0x808080 → outputs 0x000000 and 0x0000FF.
- In RUN with mode 000, SOF with mode 010 → in_ready_o low for 18 cycles and start_sobel_i never pulses; in the reverse direction (010→000) start_sobel_i pulses exactly once, in START.
- out_ready_i=0 with continuous bypass input → in_ready_o drops when count > FIFO_DEPTH−RESERVE; no drop, overflow_o stays 0; releasing out_ready_i delivers pixels in order.
- Force a core result into a full FIFO (RESERVE=0 variant) → overflow_o=1 and stays 1 until reset_i.
- Assert reset_i in DRAIN with 3 pixels in the FIFO → next cycle out_valid_o=0, in_ready_o=1, active_mode_o=011.
